// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the load/store unit: word width, LSU FSM states,
// funct3 access codes and size/alignment helpers.
package cpu_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Unlisted encodings (011, 110, 111) fall through to a full word.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_B;
      F3_LH, F3_LHU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3_size(f3))
      SZ_H:    return lo[0];
      SZ_W:    return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the LSU: byte enables, store-data replication
// and load lane extraction with sign/zero extension.
module lsu_align
  import cpu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [WORD-1:0] wdata,
  input  logic [WORD-1:0] rdata,
  output logic [3:0]      be,
  output logic [WORD-1:0] wdata_rep,
  output logic [WORD-1:0] ld_ext
);

  lsu_size_t   size;
  logic        uns;
  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  always_comb begin
    size      = f3_size(funct3);
    uns       = funct3[2];
    b_lane    = rdata[{addr_lo, 3'b000} +: 8];
    // Halfword lanes use addr[1] only, so an odd address is aligned down.
    h_lane    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    be        = 4'b1111;
    wdata_rep = wdata;
    ld_ext    = rdata;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        ld_ext    = {{24{~uns & b_lane[7]}}, b_lane};
      end
      SZ_H: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        ld_ext    = {{16{~uns & h_lane[15]}}, h_lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding access on a valid/grant memory port, PC stall
// until completion. Misalignment trapping is enabled by LSU_MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | no access in flight; capture request when req_valid
// REQ   | mem_req high, fields held until mem_gnt
// WAIT  | load granted, waiting for mem_rvalid
// DONE  | access retires: stall released, ld_valid for loads
module lsu
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_t        state;
  logic [ADDR_W-1:0] addr_r;
  logic              we_r;
  logic [2:0]        f3_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] ld_data_r;
  logic              mis_r;

  logic              trap;
  logic              in_req;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] ld_ext;

  assign trap = TRAP_EN && f3_misaligned(req_funct3, req_addr[1:0]);

  lsu_align u_align (
    .funct3    (f3_r),
    .addr_lo   (addr_r[1:0]),
    .wdata     (wdata_r),
    .rdata     (mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .ld_ext    (ld_ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_r    <= '0;
      we_r      <= 1'b0;
      f3_r      <= '0;
      wdata_r   <= '0;
      ld_data_r <= '0;
      mis_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_r  <= req_addr;
            we_r    <= req_we;
            f3_r    <= req_funct3;
            wdata_r <= req_wdata;
            if (trap) begin
              mis_r <= 1'b1;
              state <= DONE;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            if (we_r) begin
              mis_r <= 1'b0;
              state <= DONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            ld_data_r <= ld_ext;
            mis_r     <= 1'b0;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory fields are zero outside REQ so nothing stale leaks onto the port.
  assign in_req    = (state == REQ);
  assign mem_req   = in_req;
  assign mem_we    = in_req & we_r;
  assign mem_addr  = in_req ? {addr_r[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = in_req ? wdata_rep : '0;
  assign mem_be    = in_req ? be : 4'b0000;

  assign stall    = (state != DONE) & (req_valid | (state != IDLE));
  assign ld_valid = (state == DONE) & ~we_r & ~mis_r;
  assign ld_data  = ld_data_r;
  assign misalign = TRAP_EN & mis_r;

endmodule
